// File: rtl/branch_predict_unit.sv
// Branch unit: direct-mapped tagged target table with 2-bit saturating counters.
// Predicts at fetch (pred_*), resolves at execute (res_*) and trains the table on resolve.
module branch_predict_unit #(
   parameter int XLEN     = 32,
   parameter int ENTRIES  = 16,
   parameter int CTR_INIT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pred_valid,
   input  logic [XLEN-1:0] pred_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            res_valid,
   input  logic [1:0]      res_condition,
   input  logic [XLEN-1:0] res_alu_result,
   input  logic [XLEN-1:0] res_pc,
   input  logic [XLEN-1:0] res_immediate,
   input  logic            res_pred_taken,
   input  logic [XLEN-1:0] res_pred_target,
   output logic            branch_taken,
   output logic [XLEN-1:0] branch_addr,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_addr
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;
   localparam logic [1:0] CTR_RST = 2'(CTR_INIT);

   typedef enum logic [1:0] {
      COND_ALU_ZERO    = 2'd0,
      COND_ALU_NONZERO = 2'd1,
      COND_FORCE_FALSE = 2'd2,
      COND_FORCE_TRUE  = 2'd3
   } cond_e;

   logic             valid_q  [ENTRIES];
   logic             valid_d  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [TAG_W-1:0] tag_d    [ENTRIES];
   logic [XLEN-1:0]  target_q [ENTRIES];
   logic [XLEN-1:0]  target_d [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];
   logic [1:0]       ctr_d    [ENTRIES];

   logic            pred_taken_q, pred_taken_d;
   logic [XLEN-1:0] pred_target_q, pred_target_d;
   logic            branch_taken_q, branch_taken_d;
   logic [XLEN-1:0] branch_addr_q, branch_addr_d;
   logic            mispredict_q, mispredict_d;
   logic [XLEN-1:0] redirect_addr_q, redirect_addr_d;

   logic [IDX_W-1:0] pred_idx, res_idx;
   logic [TAG_W-1:0] pred_tag, res_tag;
   logic             pred_hit, res_hit, res_taken;
   logic [XLEN-1:0]  res_branch_addr, res_fallthrough;
   cond_e            res_cond;

   // The low two PC bits never select or tag an entry.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[1:0], res_pc[1:0]};

   assign pred_idx = pred_pc[IDX_W+1:2];
   assign pred_tag = pred_pc[XLEN-1:IDX_W+2];
   assign res_idx  = res_pc[IDX_W+1:2];
   assign res_tag  = res_pc[XLEN-1:IDX_W+2];
   assign res_cond = cond_e'(res_condition);

   assign pred_hit        = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
   assign res_hit         = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
   assign res_branch_addr = res_pc + res_immediate;
   assign res_fallthrough = res_pc + XLEN'(4);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      res_taken = 1'b0;
      unique case (res_cond)
         COND_ALU_ZERO:    res_taken = (res_alu_result == '0);
         COND_ALU_NONZERO: res_taken = (res_alu_result != '0);
         COND_FORCE_FALSE: res_taken = 1'b0;
         COND_FORCE_TRUE:  res_taken = 1'b1;
         default:          res_taken = 1'b0;
      endcase
   end

   // Lookup reads the pre-update table, so a same-cycle train is seen one cycle later.
   always_comb begin
      pred_taken_d  = pred_valid && pred_hit && ctr_q[pred_idx][1];
      pred_target_d = pred_target_q;
      if (pred_valid) begin
         pred_target_d = pred_taken_d ? target_q[pred_idx] : pred_pc + XLEN'(4);
      end
   end

   always_comb begin
      branch_taken_d  = res_valid && res_taken;
      branch_addr_d   = res_valid ? res_branch_addr : branch_addr_q;
      redirect_addr_d = redirect_addr_q;
      mispredict_d    = 1'b0;
      if (res_valid) begin
         redirect_addr_d = res_taken ? res_branch_addr : res_fallthrough;
         mispredict_d    = (res_taken != res_pred_taken) ||
                           (res_taken && (res_branch_addr != res_pred_target));
      end
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (res_valid && (res_cond != COND_FORCE_FALSE)) begin
         if (res_hit) begin
            if (res_taken) begin
               if (ctr_q[res_idx] != 2'd3) ctr_d[res_idx] = ctr_q[res_idx] + 2'd1;
               target_d[res_idx] = res_branch_addr;
            end else if (ctr_q[res_idx] != 2'd0) begin
               ctr_d[res_idx] = ctr_q[res_idx] - 2'd1;
            end
         end else if (res_taken) begin
            // Taken miss evicts whatever lives at this index and starts weakly taken.
            valid_d[res_idx]  = 1'b1;
            tag_d[res_idx]    = res_tag;
            target_d[res_idx] = res_branch_addr;
            ctr_d[res_idx]    = 2'd2;
         end
      end
   end

   // NOTE: the table is reset entry by entry; a cold entry must never hit on stale tags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_RST;
         end
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         ctr_q    <= ctr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pred_taken_q    <= 1'b0;
         pred_target_q   <= '0;
         branch_taken_q  <= 1'b0;
         branch_addr_q   <= '0;
         mispredict_q    <= 1'b0;
         redirect_addr_q <= '0;
      end else begin
         pred_taken_q    <= pred_taken_d;
         pred_target_q   <= pred_target_d;
         branch_taken_q  <= branch_taken_d;
         branch_addr_q   <= branch_addr_d;
         mispredict_q    <= mispredict_d;
         redirect_addr_q <= redirect_addr_d;
      end
   end

   assign pred_taken    = pred_taken_q;
   assign pred_target   = pred_target_q;
   assign branch_taken  = branch_taken_q;
   assign branch_addr   = branch_addr_q;
   assign mispredict    = mispredict_q;
   assign redirect_addr = redirect_addr_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a driver pushes expected responses from a
// behavioural model, a monitor pops and compares one record per clock.
module tb_branch_predict_unit;

   localparam int N = 16;
   localparam logic [1:0] C_ZERO    = 2'd0;
   localparam logic [1:0] C_NONZERO = 2'd1;
   localparam logic [1:0] C_FFALSE  = 2'd2;
   localparam logic [1:0] C_FTRUE   = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pred_valid = 1'b0;
   logic [31:0] pred_pc = '0;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        res_valid = 1'b0;
   logic [1:0]  res_condition = '0;
   logic [31:0] res_alu_result = '0;
   logic [31:0] res_pc = '0;
   logic [31:0] res_immediate = '0;
   logic        res_pred_taken = 1'b0;
   logic [31:0] res_pred_target = '0;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        mispredict;
   logic [31:0] redirect_addr;

   branch_predict_unit dut (
      .clk(clk), .rst(rst),
      .pred_valid(pred_valid), .pred_pc(pred_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .res_valid(res_valid), .res_condition(res_condition),
      .res_alu_result(res_alu_result), .res_pc(res_pc),
      .res_immediate(res_immediate), .res_pred_taken(res_pred_taken),
      .res_pred_target(res_pred_target),
      .branch_taken(branch_taken), .branch_addr(branch_addr),
      .mispredict(mispredict), .redirect_addr(redirect_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        pt;
      bit [31:0] ptg;
      bit        bt;
      bit [31:0] ba;
      bit        mp;
      bit [31:0] ra;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   // Reference model: each slot remembers which word address owns it.
   bit        m_valid [N];
   bit [31:0] m_owner [N];
   bit [31:0] m_tgt   [N];
   int        m_ctr   [N];
   bit [31:0] m_last_ptg, m_last_ba, m_last_ra;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0; m_owner[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_last_ptg = 0; m_last_ba = 0; m_last_ra = 0;
   endtask

   function automatic int slot_of(input bit [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic bit owns(input bit [31:0] pc);
      return m_valid[slot_of(pc)] && (m_owner[slot_of(pc)] == (pc >> 2));
   endfunction

   function automatic bit model_taken_pred(input bit [31:0] pc);
      return owns(pc) && (m_ctr[slot_of(pc)] >= 2);
   endfunction

   function automatic bit [31:0] model_target_pred(input bit [31:0] pc);
      return model_taken_pred(pc) ? m_tgt[slot_of(pc)] : pc + 32'd4;
   endfunction

   task automatic issue(input bit pv, input bit [31:0] ppc,
                        input bit rv, input bit [1:0] cond, input bit [31:0] alu,
                        input bit [31:0] rpc, input bit [31:0] imm,
                        input bit rpt, input bit [31:0] rptg);
      exp_t e;
      bit tk;
      bit [31:0] ba;
      int s;
      @(negedge clk);
      pred_valid = pv; pred_pc = ppc;
      res_valid = rv; res_condition = cond; res_alu_result = alu;
      res_pc = rpc; res_immediate = imm; res_pred_taken = rpt; res_pred_target = rptg;
      e.pt = 0;
      e.ptg = m_last_ptg;
      if (pv) begin
         e.pt = model_taken_pred(ppc);
         e.ptg = model_target_pred(ppc);
         m_last_ptg = e.ptg;
      end
      e.bt = 0; e.mp = 0; e.ba = m_last_ba; e.ra = m_last_ra;
      if (rv) begin
         case (cond)
            C_ZERO:    tk = (alu == 0);
            C_NONZERO: tk = (alu != 0);
            C_FFALSE:  tk = 0;
            default:   tk = 1;
         endcase
         ba = rpc + imm;
         e.bt = tk;
         e.ba = ba;
         e.ra = tk ? ba : rpc + 32'd4;
         e.mp = (tk != rpt) || (tk && ba != rptg);
         m_last_ba = e.ba;
         m_last_ra = e.ra;
         s = slot_of(rpc);
         if (cond != C_FFALSE) begin
            if (owns(rpc)) begin
               m_ctr[s] = tk ? ((m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1)
                             : ((m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1);
               if (tk) m_tgt[s] = ba;
            end else if (tk) begin
               m_valid[s] = 1; m_owner[s] = rpc >> 2; m_tgt[s] = ba; m_ctr[s] = 2;
            end
         end
      end
      sb.push_back(e);
   endtask

   task automatic lookup(input bit [31:0] pc);
      issue(1, pc, 0, C_ZERO, 0, 0, 0, 0, 0);
   endtask

   task automatic resolve(input bit [1:0] cond, input bit [31:0] alu, input bit [31:0] pc,
                          input bit [31:0] imm, input bit rpt, input bit [31:0] rptg);
      issue(0, 0, 1, cond, alu, pc, imm, rpt, rptg);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pred_taken"}, 32'(pred_taken), 0);
      check({tag, "_pred_target"}, pred_target, 0);
      check({tag, "_branch_taken"}, 32'(branch_taken), 0);
      check({tag, "_branch_addr"}, branch_addr, 0);
      check({tag, "_mispredict"}, 32'(mispredict), 0);
      check({tag, "_redirect_addr"}, redirect_addr, 0);
   endtask

   function automatic bit [31:0] rand_pc();
      bit [31:0] pc;
      pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) pc = pc | 32'hFFFF_FF00;
      return pc;
   endfunction

   // Monitor: one registered response per clock for every issued cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_pred_taken", 32'(pred_taken), 32'(e.pt));
            check("sb_pred_target", pred_target, e.ptg);
            check("sb_branch_taken", 32'(branch_taken), 32'(e.bt));
            check("sb_branch_addr", branch_addr, e.ba);
            check("sb_mispredict", 32'(mispredict), 32'(e.mp));
            check("sb_redirect_addr", redirect_addr, e.ra);
         end
      end
   end

   initial begin
      bit [31:0] rpc, alu, imm, rptg;
      bit rpt;
      int budget;
      model_reset();
      #12;
      check_outputs_zero("reset");
      #3 rst = 1'b0;

      // Taken miss allocates and flags a mispredict; then predicts taken.
      resolve(C_NONZERO, 5, 32'h40, -32'sd8, 0, 32'h44);
      settle();
      check("t2_branch_taken", 32'(branch_taken), 1);
      check("t2_branch_addr", branch_addr, 32'h38);
      check("t2_mispredict", 32'(mispredict), 1);
      check("t2_redirect", redirect_addr, 32'h38);
      lookup(32'h40);
      settle();
      check("t2_pred_taken", 32'(pred_taken), 1);
      check("t2_pred_target", pred_target, 32'h38);

      // Counter saturation and decay.
      repeat (2) resolve(C_NONZERO, 1, 32'h40, -32'sd8, 1, 32'h38);
      resolve(C_ZERO, 3, 32'h40, -32'sd8, 1, 32'h38);
      lookup(32'h40);
      settle();
      check("t3_still_taken", 32'(pred_taken), 1);
      repeat (2) resolve(C_ZERO, 3, 32'h40, -32'sd8, 1, 32'h38);
      settle();
      check("t3_mispredict", 32'(mispredict), 1);
      check("t3_redirect", redirect_addr, 32'h44);
      lookup(32'h40);
      settle();
      check("t3_pred_not_taken", 32'(pred_taken), 0);
      check("t3_pred_target", pred_target, 32'h44);

      // Same-cycle lookup and train of one index.
      repeat (2) resolve(C_NONZERO, 9, 32'h40, -32'sd8, 0, 32'h44);
      issue(1, 32'h40, 1, C_ZERO, 3, 32'h40, -32'sd8, 1, 32'h38);
      settle();
      check("t6_old_taken", 32'(pred_taken), 1);
      check("t6_old_target", pred_target, 32'h38);
      lookup(32'h40);
      settle();
      check("t6_new_taken", 32'(pred_taken), 0);
      check("t6_new_target", pred_target, 32'h44);

      // Aliasing eviction at index 0.
      resolve(C_FTRUE, 0, 32'h80, 32'h10, 0, 32'h84);
      lookup(32'h40);
      settle();
      check("t4_evicted_taken", 32'(pred_taken), 0);
      check("t4_evicted_target", pred_target, 32'h44);
      lookup(32'h80);
      settle();
      check("t4_new_taken", 32'(pred_taken), 1);
      check("t4_new_target", pred_target, 32'h90);

      // Address wrap and FORCE_FALSE leaves the table alone.
      resolve(C_FTRUE, 0, 32'hFFFF_FFFC, 32'h8, 0, 32'h0);
      settle();
      check("t5_wrap_taken", 32'(branch_taken), 1);
      check("t5_wrap_addr", branch_addr, 32'h4);
      check("t5_wrap_redirect", redirect_addr, 32'h4);
      resolve(C_FFALSE, 0, 32'h80, 32'h40, 1, 32'h90);
      settle();
      check("t5_ff_taken", 32'(branch_taken), 0);
      check("t5_ff_mispredict", 32'(mispredict), 1);
      check("t5_ff_redirect", redirect_addr, 32'h84);
      lookup(32'h80);
      settle();
      check("t5_ff_no_write", 32'(pred_taken), 1);

      // Asynchronous reset with an update and lookup pending.
      #1;
      pred_valid = 1; pred_pc = 32'h80;
      res_valid = 1; res_condition = C_FTRUE; res_pc = 32'h40; res_immediate = 32'h100;
      #2 rst = 1'b1;
      #1 check_outputs_zero("rst_async");
      settle();
      check_outputs_zero("rst_held");
      pred_valid = 0; res_valid = 0;
      model_reset();
      #2 rst = 1'b0;
      lookup(32'h40);
      settle();
      check("t1_pred_taken", 32'(pred_taken), 0);
      check("t1_pred_target", pred_target, 32'h44);
      lookup(32'h80);
      settle();
      check("t1_evicted_by_rst", 32'(pred_taken), 0);

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         rpc = rand_pc();
         alu = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
         imm = ($urandom_range(0, 7) == 0) ? $urandom
                                           : 32'((int'($urandom_range(0, 63)) - 32) * 4);
         if ($urandom_range(0, 3) != 0) begin
            rpt = model_taken_pred(rpc);
            rptg = model_target_pred(rpc);
         end else begin
            rpt = 1'($urandom);
            rptg = rand_pc();
         end
         issue(1'($urandom), rand_pc(), 1'($urandom_range(0, 3) != 0),
               2'($urandom_range(0, 3)), alu, rpc, imm, rpt, rptg);
      end

      budget = 0;
      while (sb.size() != 0 && budget < 50) begin
         @(posedge clk);
         budget++;
      end
      #3;
      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
